hizali_bellek_islem_birimi: RTL and testbench

- Parametrised load/store unit between the execute stage and the L1 data cache.
- Places store data and byte masks on the correct lanes from the low address bits.
- Extracts and sign/zero-extends load data from the addressed lanes.
- Handles misaligned accesses by splitting them into two bus accesses, or by flagging an exception, using a small FSM with a start/done handshake.

---
 rtl/hizali_bellek_islem_birimi.sv | 216 +++++++++++++++++++++
 tb/tb_hizali_bellek_islem_birimi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hizali_bellek_islem_birimi.sv
// Load/store unit between execute and the L1 data cache.
// Places store data and byte enables on the addressed lanes, extracts and
// extends load data, and splits or rejects misaligned accesses.
module hizali_bellek_islem_birimi #(
    parameter int VERI_BIT    = 32,
    parameter int ADR_BIT     = 32,
    parameter int HIZASIZ_BOL = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  basla_i,
    input  logic [3:0]            kontrol_i,
    input  logic [ADR_BIT-1:0]    adr_i,
    input  logic [VERI_BIT-1:0]   deger_i,
    output logic                  bitti_o,
    output logic [VERI_BIT-1:0]   sonuc_o,
    output logic                  hizasiz_o,
    output logic                  gecersiz_o,
    input  logic [VERI_BIT-1:0]   l1v_veri_i,
    input  logic                  l1v_durdur_i,
    output logic [VERI_BIT-1:0]   l1v_veri_o,
    output logic [ADR_BIT-1:0]    l1v_adr_o,
    output logic [VERI_BIT/8-1:0] l1v_veri_maske_o,
    output logic                  l1v_yaz_gecerli_o,
    output logic                  l1v_sec_n_o
);

    localparam int B  = VERI_BIT / 8;
    localparam int OB = $clog2(B);

    localparam logic [2*B-1:0]     BIR_MASKE = 1;
    localparam logic [ADR_BIT-1:0] ADIM      = ADR_BIT'(B);

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        ERISIM1 = 2'd1,
        ERISIM2 = 2'd2,
        TAMAM   = 2'd3
    } durum_t;

    durum_t durum, sonraki;

    // Latched request
    logic [2:0]          f3_r;
    logic                yaz_r;
    logic [OB-1:0]       o_r;
    logic                capraz_r;
    logic                hiz_r;
    logic                gec_r;
    logic [B-1:0]        maske2_r;
    logic [VERI_BIT-1:0] veri2_r;
    logic [VERI_BIT-1:0] w1_r;

    // Request decode
    logic [2:0]            f3_g;
    logic                  yaz_g;
    logic [OB-1:0]         o_g;
    logic [3:0]            s_g;
    logic [4:0]            uc_g;
    logic                  gecersiz_g;
    logic                  hizasiz_g;
    logic                  capraz_g;
    logic                  istisna_g;
    logic [2*B-1:0]        maske_genis;
    logic [2*VERI_BIT-1:0] veri_genis;
    logic [ADR_BIT-1:0]    adr_hiz;
    logic [VERI_BIT-1:0]   ham;
    logic [VERI_BIT-1:0]   sonuc_g;

    function automatic logic [VERI_BIT-1:0] genislet(input logic [VERI_BIT-1:0] v,
                                                     input logic [2:0] f3);
        logic [VERI_BIT-1:0] r;
        r = v;
        case (f3[1:0])
            2'b00:   r = f3[2] ? VERI_BIT'(v[7:0])  : VERI_BIT'($signed(v[7:0]));
            2'b01:   r = f3[2] ? VERI_BIT'(v[15:0]) : VERI_BIT'($signed(v[15:0]));
            2'b10:   r = f3[2] ? VERI_BIT'(v[31:0]) : VERI_BIT'($signed(v[31:0]));
            default: r = v;
        endcase
        return r;
    endfunction

    // Decode the incoming request; the two halves of the double-width shifts
    // give the first and second access lanes directly.
    always_comb begin
        f3_g        = kontrol_i[2:0];
        yaz_g       = kontrol_i[3];
        o_g         = adr_i[OB-1:0];
        s_g         = 4'd1 << f3_g[1:0];
        uc_g        = 5'(o_g) + 5'(s_g);
        gecersiz_g  = (f3_g == 3'b111)
                    || ((VERI_BIT == 32) && ((f3_g == 3'b011) || (f3_g == 3'b110)))
                    || (yaz_g && f3_g[2]);
        hizasiz_g   = |(adr_i[3:0] & (s_g - 4'd1));
        capraz_g    = uc_g > 5'(B);
        istisna_g   = gecersiz_g || (hizasiz_g && (HIZASIZ_BOL == 0));
        maske_genis = ((BIR_MASKE << s_g) - BIR_MASKE) << o_g;
        veri_genis  = {{VERI_BIT{1'b0}}, deger_i} << {o_g, 3'b000};
        adr_hiz     = {adr_i[ADR_BIT-1:OB], {OB{1'b0}}};
    end

    // Merge the captured bus words and extend the addressed bytes
    always_comb begin
        if (durum == ERISIM2)
            ham = VERI_BIT'({l1v_veri_i, w1_r} >> {o_r, 3'b000});
        else
            ham = VERI_BIT'({{VERI_BIT{1'b0}}, l1v_veri_i} >> {o_r, 3'b000});
        sonuc_g = yaz_r ? '0 : genislet(ham, f3_r);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            durum <= BOSTA;
        else
            durum <= sonraki;
    end

    // Next state and completion outputs
    always_comb begin
        sonraki    = durum;
        bitti_o    = 1'b0;
        hizasiz_o  = 1'b0;
        gecersiz_o = 1'b0;
        case (durum)
            BOSTA: begin
                if (basla_i)
                    sonraki = istisna_g ? TAMAM : ERISIM1;
            end
            ERISIM1: begin
                if (!l1v_durdur_i)
                    sonraki = capraz_r ? ERISIM2 : TAMAM;
            end
            ERISIM2: begin
                if (!l1v_durdur_i)
                    sonraki = TAMAM;
            end
            TAMAM: begin
                bitti_o    = 1'b1;
                hizasiz_o  = hiz_r;
                gecersiz_o = gec_r;
                sonraki    = BOSTA;
            end
            default: sonraki = BOSTA;
        endcase
    end

    // Request latch, bus registers and load result
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            f3_r              <= '0;
            yaz_r             <= 1'b0;
            o_r               <= '0;
            capraz_r          <= 1'b0;
            hiz_r             <= 1'b0;
            gec_r             <= 1'b0;
            maske2_r          <= '0;
            veri2_r           <= '0;
            w1_r              <= '0;
            sonuc_o           <= '0;
            l1v_veri_o        <= '0;
            l1v_adr_o         <= '0;
            l1v_veri_maske_o  <= '0;
            l1v_yaz_gecerli_o <= 1'b0;
            l1v_sec_n_o       <= 1'b1;
        end else begin
            case (durum)
                BOSTA: begin
                    if (basla_i) begin
                        f3_r     <= f3_g;
                        yaz_r    <= yaz_g;
                        o_r      <= o_g;
                        capraz_r <= capraz_g;
                        gec_r    <= gecersiz_g;
                        hiz_r    <= !gecersiz_g && hizasiz_g && (HIZASIZ_BOL == 0);
                        maske2_r <= maske_genis[2*B-1:B];
                        veri2_r  <= veri_genis[2*VERI_BIT-1:VERI_BIT];
                        sonuc_o  <= '0;
                        if (!istisna_g) begin
                            l1v_sec_n_o       <= 1'b0;
                            l1v_adr_o         <= adr_hiz;
                            l1v_veri_maske_o  <= maske_genis[B-1:0];
                            l1v_veri_o        <= veri_genis[VERI_BIT-1:0];
                            l1v_yaz_gecerli_o <= yaz_g;
                        end
                    end
                end
                ERISIM1: begin
                    if (!l1v_durdur_i) begin
                        w1_r <= l1v_veri_i;
                        if (capraz_r) begin
                            l1v_adr_o        <= l1v_adr_o + ADIM;
                            l1v_veri_maske_o <= maske2_r;
                            l1v_veri_o       <= veri2_r;
                        end else begin
                            l1v_sec_n_o       <= 1'b1;
                            l1v_veri_maske_o  <= '0;
                            l1v_yaz_gecerli_o <= 1'b0;
                            sonuc_o           <= sonuc_g;
                        end
                    end
                end
                ERISIM2: begin
                    if (!l1v_durdur_i) begin
                        l1v_sec_n_o       <= 1'b1;
                        l1v_veri_maske_o  <= '0;
                        l1v_yaz_gecerli_o <= 1'b0;
                        sonuc_o           <= sonuc_g;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hizali_bellek_islem_birimi.sv
// Table-driven bench for the load/store unit: one instance splits misaligned
// accesses, a second one raises the misaligned exception instead.
module tb_hizali_bellek_islem_birimi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        basla = 1'b0;
    logic [3:0]  kontrol = '0;
    logic [31:0] adr = '0;
    logic [31:0] deger = '0;
    logic [31:0] rd = '0;
    logic        durdur = 1'b0;

    logic        bitti1, hiz1, gec1, yazg1, sec_n1;
    logic [31:0] sonuc1, veri1, adr1;
    logic [3:0]  maske1;
    logic        bitti0, hiz0, gec0, yazg0, sec_n0;
    logic [31:0] sonuc0, veri0, adr0;
    logic [3:0]  maske0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hizali_bellek_islem_birimi #(.VERI_BIT(32), .ADR_BIT(32), .HIZASIZ_BOL(1)) u_bol (
        .clk_i(clk), .rst_i(rst), .basla_i(basla), .kontrol_i(kontrol), .adr_i(adr),
        .deger_i(deger), .bitti_o(bitti1), .sonuc_o(sonuc1), .hizasiz_o(hiz1),
        .gecersiz_o(gec1), .l1v_veri_i(rd), .l1v_durdur_i(durdur), .l1v_veri_o(veri1),
        .l1v_adr_o(adr1), .l1v_veri_maske_o(maske1), .l1v_yaz_gecerli_o(yazg1),
        .l1v_sec_n_o(sec_n1)
    );

    hizali_bellek_islem_birimi #(.VERI_BIT(32), .ADR_BIT(32), .HIZASIZ_BOL(0)) u_exc (
        .clk_i(clk), .rst_i(rst), .basla_i(basla), .kontrol_i(kontrol), .adr_i(adr),
        .deger_i(deger), .bitti_o(bitti0), .sonuc_o(sonuc0), .hizasiz_o(hiz0),
        .gecersiz_o(gec0), .l1v_veri_i(rd), .l1v_durdur_i(durdur), .l1v_veri_o(veri0),
        .l1v_adr_o(adr0), .l1v_veri_maske_o(maske0), .l1v_yaz_gecerli_o(yazg0),
        .l1v_sec_n_o(sec_n0)
    );

    typedef struct {
        string       ad;
        logic [3:0]  kontrol;
        logic [31:0] adr;
        logic [31:0] deger;
        logic [31:0] rd1;
        logic [31:0] rd2;
        int          n_erisim;
        logic [31:0] adr1;
        logic [3:0]  maske1;
        logic [31:0] veri1;
        logic [31:0] adr2;
        logic [3:0]  maske2;
        logic [31:0] veri2;
        logic [31:0] sonuc;
        logic        gec;
        int          gecikme;
        logic        hiz0;
    } vek_t;

    vek_t tablo[16];

    task automatic karsilastir(input string ad, input logic [63:0] gercek,
                               input logic [63:0] beklenen);
        n_vec++;
        if (gercek !== beklenen) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
        end
    endtask

    task automatic calistir(input vek_t v);
        int  k;
        int  b1;
        int  b0;
        bit  erisim0;
        @(negedge clk);
        basla   = 1'b1;
        kontrol = v.kontrol;
        adr     = v.adr;
        deger   = v.deger;
        @(posedge clk);
        #1 basla = 1'b0;
        k = 0; b1 = -1; b0 = -1; erisim0 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!sec_n1) begin
                if (k == 0) begin
                    karsilastir({v.ad, " adr1"},   adr1,   v.adr1);
                    karsilastir({v.ad, " maske1"}, maske1, v.maske1);
                    karsilastir({v.ad, " veri1"},  veri1,  v.veri1);
                    karsilastir({v.ad, " yaz1"},   yazg1,  v.kontrol[3]);
                    rd = v.rd1;
                end else if (k == 1) begin
                    karsilastir({v.ad, " adr2"},   adr2_of(adr1), v.adr2);
                    karsilastir({v.ad, " maske2"}, maske1, v.maske2);
                    karsilastir({v.ad, " veri2"},  veri1,  v.veri2);
                    karsilastir({v.ad, " yaz2"},   yazg1,  v.kontrol[3]);
                    rd = v.rd2;
                end
                k++;
            end
            if (!sec_n0) erisim0 = 1'b1;
            if (bitti1) begin
                if (b1 < 0) begin
                    b1 = c;
                    karsilastir({v.ad, " sonuc"},   sonuc1, v.sonuc);
                    karsilastir({v.ad, " gecersiz"}, gec1,  v.gec);
                    karsilastir({v.ad, " hizasiz"},  hiz1,  1'b0);
                end else begin
                    karsilastir({v.ad, " bitti pulse"}, c, b1);
                end
            end
            if (bitti0) begin
                if (b0 < 0) begin
                    b0 = c;
                    karsilastir({v.ad, " exc hizasiz"},  hiz0,   v.hiz0);
                    karsilastir({v.ad, " exc gecersiz"}, gec0,   v.gec);
                    karsilastir({v.ad, " exc sonuc"},    sonuc0, v.hiz0 ? 32'h0 : v.sonuc);
                end else begin
                    karsilastir({v.ad, " exc bitti pulse"}, c, b0);
                end
            end
        end
        karsilastir({v.ad, " gecikme"},     b1, v.gecikme);
        karsilastir({v.ad, " erisim sayisi"}, k, v.n_erisim);
        karsilastir({v.ad, " exc gecikme"}, b0, v.hiz0 ? 1 : v.gecikme);
        karsilastir({v.ad, " exc erisim"},  erisim0, (v.n_erisim > 0) && !v.hiz0);
    endtask

    function automatic logic [31:0] adr2_of(input logic [31:0] a);
        return a;
    endfunction

    initial begin
        tablo[0]  = '{"LB",       4'h0, 32'h103, 32'h0, 32'h80FFFF00, 32'h0, 1,
                      32'h100, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0};
        tablo[1]  = '{"SH",       4'h9, 32'h202, 32'h0000ABCD, 32'h12345678, 32'h0, 1,
                      32'h200, 4'b1100, 32'hABCD0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2, 1'b0};
        tablo[2]  = '{"LW_SPLIT", 4'h2, 32'h0FE, 32'h0, 32'hBBAA1111, 32'h2222DDCC, 2,
                      32'h0FC, 4'b1100, 32'h0, 32'h100, 4'b0011, 32'h0, 32'hDDCCBBAA, 1'b0, 3, 1'b1};
        tablo[3]  = '{"LBU",      4'h4, 32'h101, 32'h0, 32'h0000F000, 32'h0, 1,
                      32'h100, 4'b0010, 32'h0, 32'h0, 4'h0, 32'h0, 32'h000000F0, 1'b0, 2, 1'b0};
        tablo[4]  = '{"LH",       4'h1, 32'h106, 32'h0, 32'h80010000, 32'h0, 1,
                      32'h104, 4'b1100, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 2, 1'b0};
        tablo[5]  = '{"LW",       4'h2, 32'h208, 32'h0, 32'hCAFEBABE, 32'h0, 1,
                      32'h208, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 32'hCAFEBABE, 1'b0, 2, 1'b0};
        tablo[6]  = '{"SW",       4'hA, 32'h010, 32'hDEADBEEF, 32'h0, 32'h0, 1,
                      32'h010, 4'b1111, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2, 1'b0};
        tablo[7]  = '{"SB",       4'h8, 32'h011, 32'h1234565A, 32'h0, 32'h0, 1,
                      32'h010, 4'b0010, 32'h34565A00, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2, 1'b0};
        tablo[8]  = '{"LH_MIS",   4'h1, 32'h101, 32'h0, 32'h00ABCD00, 32'h0, 1,
                      32'h100, 4'b0110, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFABCD, 1'b0, 2, 1'b1};
        tablo[9]  = '{"ILL111",   4'h7, 32'h100, 32'h0, 32'h0, 32'h0, 0,
                      32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0};
        tablo[10] = '{"LD32",     4'h3, 32'h100, 32'h0, 32'h0, 32'h0, 0,
                      32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0};
        tablo[11] = '{"SBU",      4'hC, 32'h100, 32'h0, 32'h0, 32'h0, 0,
                      32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0};
        tablo[12] = '{"SW_SPLIT", 4'hA, 32'h0FF, 32'hAABBCCDD, 32'h0, 32'h0, 2,
                      32'h0FC, 4'b1000, 32'hDD000000, 32'h100, 4'b0111, 32'h00AABBCC, 32'h0, 1'b0, 3, 1'b1};
        tablo[13] = '{"LH_SPLIT", 4'h1, 32'h1FF, 32'h0, 32'h7F000000, 32'h000000FF, 2,
                      32'h1FC, 4'b1000, 32'h0, 32'h200, 4'b0001, 32'h0, 32'hFFFFFF7F, 1'b0, 3, 1'b1};
        tablo[14] = '{"LW_WRAP",  4'h2, 32'hFFFFFFFE, 32'h0, 32'h11220000, 32'h00003344, 2,
                      32'hFFFFFFFC, 4'b1100, 32'h0, 32'h0, 4'b0011, 32'h0, 32'h33441122, 1'b0, 3, 1'b1};
        tablo[15] = '{"LWU32",    4'h6, 32'h100, 32'h0, 32'h0, 32'h0, 0,
                      32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        karsilastir("reset bitti",   {bitti1, bitti0}, 2'b00);
        karsilastir("reset bayrak",  {hiz1, gec1, hiz0, gec0}, 4'b0000);
        karsilastir("reset sec_n",   {sec_n1, sec_n0}, 2'b11);
        karsilastir("reset yaz",     {yazg1, yazg0}, 2'b00);
        karsilastir("reset sonuc",   {sonuc1, sonuc0}, 64'h0);
        karsilastir("reset veri",    {veri1, veri0}, 64'h0);
        karsilastir("reset adr",     {adr1, adr0}, 64'h0);
        karsilastir("reset maske",   {maske1, maske0}, 8'h00);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) calistir(tablo[i]);

        // LHU with the cache stalling for three cycles
        @(negedge clk);
        basla = 1'b1; kontrol = 4'h5; adr = 32'h102; deger = 32'h0; durdur = 1'b1;
        @(posedge clk);
        #1 basla = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                karsilastir("stall sec_n", sec_n1, 1'b0);
                karsilastir("stall adr",   adr1,   32'h100);
                karsilastir("stall maske", maske1, 4'b1100);
                karsilastir("stall veri",  veri1,  32'h0);
                karsilastir("stall bitti", bitti1, 1'b0);
            end
            if (c == 4) begin
                durdur = 1'b0;
                rd     = 32'h98760000;
            end
            if (c == 5) begin
                karsilastir("stall bitti5", {bitti1, bitti0}, 2'b11);
                karsilastir("stall sonuc",  sonuc1, 32'h00009876);
                karsilastir("stall sonuc exc", sonuc0, 32'h00009876);
            end
            if (c == 6) karsilastir("stall bitti6", bitti1, 1'b0);
        end

        // Reset in the middle of a split store
        @(negedge clk);
        basla = 1'b1; kontrol = 4'hA; adr = 32'h0FF; deger = 32'hAABBCCDD;
        @(posedge clk);
        #1 basla = 1'b0;
        @(negedge clk);
        karsilastir("rst acc1 maske", maske1, 4'b1000);
        @(negedge clk);
        karsilastir("rst acc2 maske", maske1, 4'b0111);
        rst = 1'b0;
        @(negedge clk);
        karsilastir("rst sec_n", sec_n1, 1'b1);
        karsilastir("rst maske", maske1, 4'b0000);
        karsilastir("rst bitti", bitti1, 1'b0);
        karsilastir("rst bus",   {adr1, veri1, 31'h0, yazg1}, 96'h0);
        rst = 1'b1;
        @(negedge clk);
        karsilastir("rst idle bitti", bitti1, 1'b0);
        calistir(tablo[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
